pwm_carrier_gen: RTL

//  Parametrised carrier generator for one PWM channel group.

---
 rtl/pwm_carrier_gen_pkg.sv | 39 +++
 rtl/pwm_carrier_gen_if.sv | 41 ++++
 rtl/pwm_carrier_gen_clkdiv.sv | 40 ++++
 rtl/pwm_carrier_gen.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/pwm_carrier_gen_pkg.sv
// Shared types for the PWM carrier generator.
//   - default widths for the carrier counter, prescaler and event decimator
//   - enums for counting mode, event mask and the on/off controls
//   - evt_qualifies(): decides whether a min/max event feeds the interrupt decimator
package pwm_carrier_gen_pkg;

  localparam int PWMCOUNT_WIDTH = 16;
  localparam int DIVCLK_WIDTH   = 4;
  localparam int EVTCOUNT_WIDTH = 3;

  typedef enum logic [1:0] {
    NO_COUNT     = 2'd0,
    COUNT_UP     = 2'd1,
    COUNT_DOWN   = 2'd2,
    COUNT_UPDOWN = 2'd3
  } count_mode_e;

  typedef enum logic [1:0] {
    NO_MASK     = 2'd0,
    MIN_MASK    = 2'd1,
    MAX_MASK    = 2'd2,
    MINMAX_MASK = 2'd3
  } mask_mode_e;

  typedef enum logic {INT_OFF    = 1'b0, INT_ON    = 1'b1} int_onoff_e;
  typedef enum logic {CLKDIV_OFF = 1'b0, CLKDIV_ON = 1'b1} clkdiv_onoff_e;
  typedef enum logic {CARR_OFF   = 1'b0, CARR_ON   = 1'b1} carr_onoff_e;

  // A simultaneous min and max collapses to a single qualifying event.
  function automatic logic evt_qualifies(mask_mode_e mask, logic emin, logic emax);
    case (mask)
      NO_MASK:  return 1'b0;
      MIN_MASK: return emin;
      MAX_MASK: return emax;
      default:  return emin | emax;
    endcase
  endfunction

endpackage

// File: rtl/pwm_carrier_gen_if.sv
// Configuration and status bundle of one PWM carrier.
//   master: the controller side (drives configuration, observes carrier status)
//   slave : the carrier generator
//   config : carr_on, clkdiv_on, clk_div, count_mode, mask_mode, int_on, period, evt_div, sync_in
//   status : cnt_o, dir_o, tick_o, evt_min_o, evt_max_o, irq_o
interface pwm_carrier_gen_if
  import pwm_carrier_gen_pkg::*;
#(
  parameter int CNT_W = PWMCOUNT_WIDTH,
  parameter int DIV_W = DIVCLK_WIDTH,
  parameter int EVT_W = EVTCOUNT_WIDTH
);

  logic              carr_on;
  logic              clkdiv_on;
  logic [DIV_W-1:0]  clk_div;
  count_mode_e       count_mode;
  mask_mode_e        mask_mode;
  logic              int_on;
  logic [CNT_W-1:0]  period;
  logic [EVT_W-1:0]  evt_div;
  logic              sync_in;

  logic [CNT_W-1:0]  cnt_o;
  logic              dir_o;
  logic              tick_o;
  logic              evt_min_o;
  logic              evt_max_o;
  logic              irq_o;

  modport master (
    output carr_on, clkdiv_on, clk_div, count_mode, mask_mode, int_on, period, evt_div, sync_in,
    input  cnt_o, dir_o, tick_o, evt_min_o, evt_max_o, irq_o
  );

  modport slave (
    input  carr_on, clkdiv_on, clk_div, count_mode, mask_mode, int_on, period, evt_div, sync_in,
    output cnt_o, dir_o, tick_o, evt_min_o, evt_max_o, irq_o
  );

endinterface

// File: rtl/pwm_carrier_gen_clkdiv.sv
// Carrier prescaler.
//   clk, rst_n : system clock, synchronous active-low reset
//   en         : carrier running
//   clr        : restart the prescale count (carrier off or phase resync)
//   div_on     : 0 = tick every clk, 1 = tick every div+1 clk
//   div        : divide value, may change while running
//   tick       : combinational tick qualifying the carrier step on this edge
module pwm_carrier_gen_clkdiv #(
  parameter int DIV_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             clr,
  input  logic             div_on,
  input  logic [DIV_W-1:0] div,
  output logic             tick
);

  localparam logic [DIV_W-1:0] DIV_ONE = DIV_W'(1);

  logic [DIV_W-1:0] pcnt;
  logic             hit;

  // >= rather than == so that lowering div below the running count
  // terminates at the next compare instead of wrapping the whole range.
  assign hit  = (pcnt >= div);
  assign tick = en && !clr && (!div_on || hit);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pcnt <= '0;
    end else if (clr || !div_on) begin
      pcnt <= '0;
    end else if (en) begin
      pcnt <= hit ? '0 : pcnt + DIV_ONE;
    end
  end

endmodule

// File: rtl/pwm_carrier_gen.sv
// PWM carrier generator: prescaled up / down / up-down counter with period
// min/max events and a decimated interrupt. Period and mode are shadowed and
// only taken over at the carrier reload point, so the carrier never glitches.
//   clk, rst_n : system clock, synchronous active-low reset
//   bus        : slave side of pwm_carrier_gen_if (configuration in, carrier status out)
//
//   active mode  | meaning
//   NO_COUNT     | hold cnt; shadows reload on every tick
//   COUNT_UP     | 0..P then wrap to 0 (reload at the wrap)
//   COUNT_DOWN   | P..0 then back to P (reload at the jump to P)
//   COUNT_UPDOWN | 0..P with dir=0, P..0 with dir=1 (reload on arrival at 0)
module pwm_carrier_gen
  import pwm_carrier_gen_pkg::*;
#(
  parameter int CNT_W = PWMCOUNT_WIDTH,
  parameter int DIV_W = DIVCLK_WIDTH,
  parameter int EVT_W = EVTCOUNT_WIDTH
) (
  input  logic               clk,
  input  logic               rst_n,
  pwm_carrier_gen_if.slave   bus
);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [EVT_W-1:0] EVT_ONE = EVT_W'(1);

  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [CNT_W-1:0] act_period, per_nxt;
  count_mode_e      act_mode, mode_nxt;
  logic             dir, dir_nxt;
  logic [EVT_W-1:0] evt_cnt, evt_cnt_nxt;
  logic             tick, reload;
  logic             min_nxt, max_nxt, qual, irq_nxt;
  logic             tick_q, evt_min_q, evt_max_q, irq_q;
  logic             running;

  assign running = (bus.carr_on == CARR_ON);

  pwm_carrier_gen_clkdiv #(.DIV_W(DIV_W)) u_clkdiv (
    .clk    (clk),
    .rst_n  (rst_n),
    .en     (running),
    .clr    (!running || bus.sync_in),
    .div_on (bus.clkdiv_on == CLKDIV_ON),
    .div    (bus.clk_div),
    .tick   (tick)
  );

  always_comb begin
    cnt_nxt     = cnt;
    dir_nxt     = dir;
    per_nxt     = act_period;
    mode_nxt    = act_mode;
    reload      = 1'b0;
    min_nxt     = 1'b0;
    max_nxt     = 1'b0;
    evt_cnt_nxt = evt_cnt;
    irq_nxt     = 1'b0;

    if (tick) begin
      case (act_mode)
        COUNT_UP: begin
          dir_nxt = 1'b0;
          if (cnt >= act_period) begin
            cnt_nxt = '0;
            reload  = 1'b1;
          end else begin
            cnt_nxt = cnt + CNT_ONE;
          end
        end
        COUNT_DOWN: begin
          if (cnt == '0) begin
            cnt_nxt = bus.period;
            // Leaving DOWN at the reload: an up-down carrier starts its
            // descent from the new top, an up carrier counts upward.
            dir_nxt = (bus.period != '0) &&
                      ((bus.count_mode == COUNT_DOWN) || (bus.count_mode == COUNT_UPDOWN));
            reload  = 1'b1;
          end else begin
            cnt_nxt = cnt - CNT_ONE;
            dir_nxt = 1'b1;
          end
        end
        COUNT_UPDOWN: begin
          if (act_period == '0) begin
            cnt_nxt = '0;
            dir_nxt = 1'b0;
            reload  = 1'b1;
          end else if (!dir) begin
            if (cnt >= act_period - CNT_ONE) begin
              cnt_nxt = act_period;
              dir_nxt = 1'b1;
            end else begin
              cnt_nxt = cnt + CNT_ONE;
            end
          end else begin
            if (cnt <= CNT_ONE) begin
              cnt_nxt = '0;
              dir_nxt = 1'b0;
              reload  = 1'b1;
            end else begin
              cnt_nxt = cnt - CNT_ONE;
            end
          end
        end
        default: reload = 1'b1;
      endcase

      if (reload) begin
        per_nxt  = bus.period;
        mode_nxt = bus.count_mode;
      end

      // A held carrier has not "reached" anything, so it raises no events.
      if (act_mode != NO_COUNT) begin
        min_nxt = (cnt_nxt == '0);
        max_nxt = (cnt_nxt == per_nxt);
      end
    end

    // Resync wins over a coincident tick (the prescaler already suppresses it).
    if (bus.sync_in) begin
      cnt_nxt = '0;
      dir_nxt = 1'b0;
      min_nxt = evt_qualifies(bus.mask_mode, 1'b1, 1'b0);
      max_nxt = 1'b0;
    end

    qual = evt_qualifies(bus.mask_mode, min_nxt, max_nxt);
    if (qual) begin
      if (evt_cnt >= bus.evt_div) begin
        evt_cnt_nxt = '0;
        irq_nxt     = (bus.int_on == INT_ON);
      end else begin
        evt_cnt_nxt = evt_cnt + EVT_ONE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt        <= '0;
      dir        <= 1'b0;
      act_period <= '0;
      act_mode   <= NO_COUNT;
      evt_cnt    <= '0;
      tick_q     <= 1'b0;
      evt_min_q  <= 1'b0;
      evt_max_q  <= 1'b0;
      irq_q      <= 1'b0;
    end else if (!running) begin
      cnt        <= '0;
      dir        <= 1'b0;
      act_period <= bus.period;
      act_mode   <= bus.count_mode;
      evt_cnt    <= '0;
      tick_q     <= 1'b0;
      evt_min_q  <= 1'b0;
      evt_max_q  <= 1'b0;
      irq_q      <= 1'b0;
    end else begin
      cnt        <= cnt_nxt;
      dir        <= dir_nxt;
      act_period <= per_nxt;
      act_mode   <= mode_nxt;
      evt_cnt    <= evt_cnt_nxt;
      tick_q     <= tick;
      evt_min_q  <= min_nxt;
      evt_max_q  <= max_nxt;
      irq_q      <= irq_nxt;
    end
  end

  assign bus.cnt_o     = cnt;
  assign bus.dir_o     = dir;
  assign bus.tick_o    = tick_q;
  assign bus.evt_min_o = evt_min_q;
  assign bus.evt_max_o = evt_max_q;
  assign bus.irq_o     = irq_q;

endmodule
